// File: rtl/serial_word_comparator.sv
// Bit-serial magnitude comparator: LANES independent lanes compare WIDTH-bit words sharing one framing.
// Optional two's-complement support is enabled by defining SERIAL_WORD_COMPARATOR_SIGNED_EN.
module serial_word_comparator #(
    parameter int WIDTH = 8,
    parameter int LANES = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             bit_valid,
    input  logic             msb_first,
`ifdef SERIAL_WORD_COMPARATOR_SIGNED_EN
    input  logic             signed_mode,
`endif
    input  logic [LANES-1:0] a,
    input  logic [LANES-1:0] b,
    output logic             res_valid,
    output logic [LANES-1:0] a_less_b,
    output logic [LANES-1:0] a_eq_b,
    output logic [LANES-1:0] a_greater_b
);

    // Handshake: bit_valid qualifies a/b (and msb_first/signed_mode at bit 0); there is no
    // backpressure, and res_valid is a one-cycle strobe qualifying the registered results.

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_EQ      = 2'b00,
        ST_LESS    = 2'b01,
        ST_GREATER = 2'b10
    } lane_st_e;

    logic [CW-1:0] cnt_q;
    logic          order_q;
    lane_st_e      st_q [LANES];
    lane_st_e      st_d [LANES];
    logic          first_bit;
    logic          last_bit;
    logic          order;
    logic          sign_bit;

`ifdef SERIAL_WORD_COMPARATOR_SIGNED_EN
    logic signed_q;
    logic signed_cur;
    assign signed_cur = first_bit ? signed_mode : signed_q;
`endif

    always_comb begin
        first_bit = (cnt_q == '0);
        last_bit  = (cnt_q == LAST_BIT);
        order     = first_bit ? msb_first : order_q;
`ifdef SERIAL_WORD_COMPARATOR_SIGNED_EN
        sign_bit  = signed_cur && (order ? first_bit : last_bit);
`else
        sign_bit  = 1'b0;
`endif
        // At the sign bit a set A bit means a negative A, so the sense of the comparison flips.
        for (int i = 0; i < LANES; i++) begin
            st_d[i] = first_bit ? ST_EQ : st_q[i];
            if ((a[i] != b[i]) && (!order || (st_d[i] == ST_EQ))) begin
                st_d[i] = (sign_bit ? a[i] : b[i]) ? ST_LESS : ST_GREATER;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q       <= '0;
            order_q     <= 1'b1;
`ifdef SERIAL_WORD_COMPARATOR_SIGNED_EN
            signed_q    <= 1'b0;
`endif
            for (int i = 0; i < LANES; i++) st_q[i] <= ST_EQ;
            res_valid   <= 1'b0;
            a_less_b    <= '0;
            a_eq_b      <= '1;
            a_greater_b <= '0;
        end else begin
            res_valid <= 1'b0;
            if (clear) begin
                cnt_q <= '0;
                for (int i = 0; i < LANES; i++) st_q[i] <= ST_EQ;
            end else if (bit_valid) begin
                cnt_q <= last_bit ? '0 : cnt_q + CW'(1);
                for (int i = 0; i < LANES; i++) st_q[i] <= st_d[i];
                if (first_bit) begin
                    order_q  <= msb_first;
`ifdef SERIAL_WORD_COMPARATOR_SIGNED_EN
                    signed_q <= signed_mode;
`endif
                end
                // The last bit is folded in combinationally, so the result lands one edge later.
                if (last_bit) begin
                    res_valid <= 1'b1;
                    for (int i = 0; i < LANES; i++) begin
                        a_less_b[i]    <= (st_d[i] == ST_LESS);
                        a_eq_b[i]      <= (st_d[i] == ST_EQ);
                        a_greater_b[i] <= (st_d[i] == ST_GREATER);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_word_comparator.sv
// Directed bench for serial_word_comparator (WIDTH=4, LANES=2) with a result scoreboard.
module tb_serial_word_comparator;

    localparam int WIDTH = 4;
    localparam int LANES = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             clear = 1'b0;
    logic             bit_valid = 1'b0;
    logic             msb_first = 1'b0;
    logic             signed_mode = 1'b0;
    logic [LANES-1:0] a = '0;
    logic [LANES-1:0] b = '0;
    logic             res_valid;
    logic [LANES-1:0] a_less_b;
    logic [LANES-1:0] a_eq_b;
    logic [LANES-1:0] a_greater_b;

    serial_word_comparator #(.WIDTH(WIDTH), .LANES(LANES)) dut (
        .clk(clk),
        .rst(rst),
        .clear(clear),
        .bit_valid(bit_valid),
        .msb_first(msb_first),
`ifdef SERIAL_WORD_COMPARATOR_SIGNED_EN
        .signed_mode(signed_mode),
`endif
        .a(a),
        .b(b),
        .res_valid(res_valid),
        .a_less_b(a_less_b),
        .a_eq_b(a_eq_b),
        .a_greater_b(a_greater_b)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    int cyc_n = 0;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    // scoreboard state: expected {lt, eq, gt}
    logic [3*LANES-1:0] exp_q[$];
    int chk_cnt = 0;
    int pass_cnt = 0;
    int rv_cnt = 0;
    int prev_rv_cyc = 0;
    int last_rv_cyc = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        chk_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, req);
    endtask

    task automatic push_exp(input logic [LANES-1:0] lt, input logic [LANES-1:0] eq,
                            input logic [LANES-1:0] gt);
        exp_q.push_back({lt, eq, gt});
    endtask

    // monitor
    always @(negedge clk) begin
        if (rst && res_valid) begin
            rv_cnt++;
            prev_rv_cyc = last_rv_cyc;
            last_rv_cyc = cyc_n;
            if (exp_q.size() == 0) begin
                check("unexpected_res_valid", 64'(rv_cnt), 64'(0));
            end else begin
                check("result", 64'({a_less_b, a_eq_b, a_greater_b}), 64'(exp_q.pop_front()));
            end
        end
    end

    // driver tasks
    task automatic cyc(input logic v, input logic [LANES-1:0] av, input logic [LANES-1:0] bv,
                       input logic m, input logic s, input logic clr);
        bit_valid   = v;
        a           = av;
        b           = bv;
        msb_first   = m;
        signed_mode = s;
        clear       = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    endtask

    // Order/sign inputs are only meaningful on bit 0; later bits drive the opposite value.
    task automatic send_word(input logic [3:0] a0, input logic [3:0] b0, input logic [3:0] a1,
                             input logic [3:0] b1, input logic msb, input logic sgn,
                             input int stall_at, input int stall_len, input int clear_at);
        int idx;
        for (int k = 0; k < WIDTH; k++) begin
            if (k == stall_at) begin
                repeat (stall_len) cyc(1'b0, '0, '0, ~msb, ~sgn, 1'b0);
            end
            idx = msb ? (WIDTH - 1 - k) : k;
            cyc(1'b1, {a1[idx], a0[idx]}, {b1[idx], b0[idx]},
                (k == 0) ? msb : ~msb, (k == 0) ? sgn : ~sgn, k == clear_at);
            if (k == clear_at) break;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_res_valid", 64'(res_valid), 64'(0));
        check("reset_lt", 64'(a_less_b), 64'(2'b00));
        check("reset_eq", 64'(a_eq_b), 64'(2'b11));
        check("reset_gt", 64'(a_greater_b), 64'(2'b00));
        rst = 1'b1;
        idle(2);

        // lane0 1010 vs 1001 -> gt, lane1 0110 vs 0110 -> eq
        push_exp(2'b00, 2'b10, 2'b01);
        send_word(4'b1010, 4'b1001, 4'b0110, 4'b0110, 1'b1, 1'b0, -1, 0, -1);
        check("latency_res_valid", 64'(res_valid), 64'(1));
        idle(1);
        check("pulse_width", 64'(res_valid), 64'(0));
        check("hold_gt", 64'(a_greater_b), 64'(2'b01));

        // LSB-first: lane0 0011 vs 0101 -> lt, lane1 0110 vs 0010 -> gt
        push_exp(2'b01, 2'b00, 2'b10);
        send_word(4'b0011, 4'b0101, 4'b0110, 4'b0010, 1'b0, 1'b0, -1, 0, -1);
        idle(2);

        // stall of 3 between bits 1 and 2: lane0 1100 vs 1010 -> gt, lane1 1001 vs 0110 -> gt
        push_exp(2'b00, 2'b00, 2'b11);
        send_word(4'b1100, 4'b1010, 4'b1001, 4'b0110, 1'b1, 1'b0, 2, 3, -1);
        idle(2);

        // back-to-back: MSB 0001 vs 0010 (lt) / 0000 vs 0000 (eq);
        // then LSB 1111 vs 1111 (eq) / 1000 vs 0111 (gt)
        push_exp(2'b01, 2'b10, 2'b00);
        push_exp(2'b00, 2'b01, 2'b10);
        send_word(4'b0001, 4'b0010, 4'b0000, 4'b0000, 1'b1, 1'b0, -1, 0, -1);
        send_word(4'b1111, 4'b1111, 4'b1000, 4'b0111, 1'b0, 1'b0, -1, 0, -1);
        idle(2);
        check("back_to_back_spacing", 64'(last_rv_cyc - prev_rv_cyc), 64'(4));

        // clear with bit_valid at bit 2 discards the word and keeps old results
        send_word(4'b0000, 4'b1111, 4'b0000, 4'b1111, 1'b1, 1'b0, -1, 0, 2);
        idle(1);
        check("clear_keeps_lt", 64'(a_less_b), 64'(2'b00));
        check("clear_keeps_eq", 64'(a_eq_b), 64'(2'b01));
        check("clear_keeps_gt", 64'(a_greater_b), 64'(2'b10));
        // lane0 0101 vs 0100 -> gt, lane1 1111 vs 1110 -> gt
        push_exp(2'b00, 2'b00, 2'b11);
        send_word(4'b0101, 4'b0100, 4'b1111, 4'b1110, 1'b1, 1'b0, -1, 0, -1);
        idle(2);

        // clear on the last bit suppresses the result; the next word starts at bit 0
        send_word(4'b0000, 4'b1111, 4'b0000, 4'b1111, 1'b1, 1'b0, -1, 0, 3);
        check("clear_last_no_valid", 64'(res_valid), 64'(0));
        // lane0 0110 vs 0111 -> lt, lane1 1010 vs 1010 -> eq
        push_exp(2'b01, 2'b10, 2'b00);
        send_word(4'b0110, 4'b0111, 4'b1010, 4'b1010, 1'b1, 1'b0, -1, 0, -1);
        idle(2);

        // asynchronous reset mid-word
        send_word(4'b1111, 4'b0000, 4'b1111, 4'b0000, 1'b1, 1'b0, -1, 0, 1);
        #2 rst = 1'b0;
        #1;
        check("async_reset_lt", 64'(a_less_b), 64'(2'b00));
        check("async_reset_eq", 64'(a_eq_b), 64'(2'b11));
        check("async_reset_gt", 64'(a_greater_b), 64'(2'b00));
        @(posedge clk);
        #1 rst = 1'b1;
        // lane0 0111 vs 1000 -> lt, lane1 0001 vs 0001 -> eq
        push_exp(2'b01, 2'b10, 2'b00);
        send_word(4'b0111, 4'b1000, 4'b0001, 4'b0001, 1'b1, 1'b0, -1, 0, -1);
        idle(2);

`ifdef SERIAL_WORD_COMPARATOR_SIGNED_EN
        // signed MSB: -8 vs 7 -> lt, -1 vs 1 -> lt
        push_exp(2'b11, 2'b00, 2'b00);
        send_word(4'b1000, 4'b0111, 4'b1111, 4'b0001, 1'b1, 1'b1, -1, 0, -1);
        // same operands unsigned -> gt, gt
        push_exp(2'b00, 2'b00, 2'b11);
        send_word(4'b1000, 4'b0111, 4'b1111, 4'b0001, 1'b1, 1'b0, -1, 0, -1);
        // signed LSB: -8 vs 7 -> lt, 2 vs -2 -> gt
        push_exp(2'b01, 2'b00, 2'b10);
        send_word(4'b1000, 4'b0111, 4'b0010, 4'b1110, 1'b0, 1'b1, -1, 0, -1);
        idle(2);
`endif

        idle(3);
        check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
`ifdef SERIAL_WORD_COMPARATOR_SIGNED_EN
        check("res_valid_count", 64'(rv_cnt), 64'(11));
`else
        check("res_valid_count", 64'(rv_cnt), 64'(8));
`endif
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/serial_word_comparator.md
SERIAL_WORD_COMPARATOR -- requirements
Module: serial_word_comparator

Interface
REQ-001 Parameter WIDTH, default 8: bits per serial word, legal range 2..64.
REQ-002 Parameter LANES, default 1: independent comparator lanes sharing one framing, legal range 1..32.
REQ-003 clk  input  1  clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 clear  input  1  synchronous abort of the word in progress.
REQ-006 bit_valid  input  1  a/b bits valid this cycle.
REQ-007 msb_first  input  1  bit order of the current word; 1 = MSB first, 0 = LSB first.
REQ-008 a  input  LANES  one serial bit of operand A per lane.
REQ-009 b  input  LANES  one serial bit of operand B per lane.
REQ-010 res_valid  output  1  one-cycle pulse, results valid.
REQ-011 a_less_b  output  LANES  per-lane result A<B, registered.
REQ-012 a_eq_b  output  LANES  per-lane result A==B, registered.
REQ-013 a_greater_b  output  LANES  per-lane result A>B, registered.

Function
REQ-014 The block SHALL count accepted bits (cycles with bit_valid=1) with a ceil(log2(WIDTH))-bit counter, 0..WIDTH-1, wrapping to 0 after the last bit.
REQ-015 The block SHALL sample msb_first only on bit 0 of a word and hold it until the word completes; msb_first changes mid-word SHALL be ignored.
REQ-016 Each lane SHALL keep a 2-bit state: EQ, LESS, GREATER; all lanes SHALL be EQ at bit 0 of every word.
REQ-017 MSB-first lane transitions: EQ->LESS on a=0,b=1; EQ->GREATER on a=1,b=0; LESS and GREATER SHALL hold until the word ends.
REQ-018 LSB-first lane transitions: any state->LESS on a=0,b=1; any state->GREATER on a=1,b=0; equal bits SHALL hold the state.
REQ-019 The decision SHALL include the current (last) bit, so a word's result reflects all WIDTH bits with no extra bit cycle.
REQ-020 Cycles with bit_valid=0 SHALL leave counter, lane states and latched order unchanged (stall allowed anywhere in a word).
REQ-021 On the clock edge accepting bit WIDTH-1, the block SHALL register final per-lane results and assert res_valid for exactly the next cycle (latency 1 cycle after the last bit).
REQ-022 Result outputs SHALL hold their last values until the next res_valid; exactly one of less/eq/greater SHALL be 1 per lane after the first result.
REQ-023 A new word's bit 0 SHALL be acceptable in the cycle immediately after the last bit of the previous word (back-to-back, no idle cycle).
REQ-024 clear=1 SHALL reset counter to 0 and lane states to EQ on the next edge, SHALL NOT assert res_valid, and SHALL NOT alter registered results.
REQ-025 clear and bit_valid both 1 SHALL give clear priority; the bit is discarded.
REQ-026 clear on the cycle of bit WIDTH-1 SHALL suppress that word's result.

Reset
REQ-027 rst=0 SHALL asynchronously force counter=0, all lane states EQ, latched order=1, res_valid=0, a_less_b=0, a_eq_b=all ones, a_greater_b=0.
REQ-028 Reset asserted mid-word SHALL discard the partial word; the first bit_valid after deassertion is bit 0.
REQ-029 Reset deassertion is synchronised externally; the block need not handle release metastability.

Configuration
REQ-030 Macro SERIAL_WORD_COMPARATOR_SIGNED_EN, when defined, SHALL add input signed_mode (1 bit, sampled with msb_first at bit 0) treating operands as two's complement.
REQ-031 With the macro and signed_mode=1, at the sign bit (bit 0 if MSB-first, bit WIDTH-1 if LSB-first) a=1,b=0 SHALL select LESS and a=0,b=1 SHALL select GREATER; all other bits unchanged.
REQ-032 Without the macro, no signed_mode port SHALL exist and all comparisons SHALL be unsigned.

Verification
REQ-033 WIDTH=4, LANES=2, MSB-first, lane0 A=1010 B=1001, lane1 A=0110 B=0110 -> one cycle after bit 3: res_valid=1, lane0 greater, lane1 eq.
REQ-034 LSB-first, A=0011 B=0101 (sent 1,1,0,0 / 1,0,1,0) -> a_less_b=1 one cycle after last bit.
REQ-035 MSB-first A=1100 B=1010 with bit_valid=0 for 3 cycles between bits 1 and 2 -> a_greater_b=1, single res_valid pulse.
REQ-036 Two back-to-back words (MSB-first 0001 vs 0010, then LSB-first 1111 vs 1111) -> res_valid on two cycles 4 apart: less, then eq.
REQ-037 clear at bit 2 of a word, then full word A=0101 B=0100 -> only one res_valid, greater; rst=0 mid-word -> outputs at reset values immediately.
REQ-038 Signed build, signed_mode=1, MSB-first A=1000 (-8) B=0111 (7) -> a_less_b=1; same with signed_mode=0 -> a_greater_b=1.
